// File: rtl/ip_codma_read_machine.sv
// CODMA bus-read engine: runs one 2/4/8-beat read burst per request
// and returns the beats in data_reg_o.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   need_read_i          read request from the main machine (IDLE only)
//   reg_addr_i           byte start address (must be word aligned)
//   reg_size_i           burst code: 3 = 2 beats, 8 = 4 beats, 9 = 8 beats
//   abort_i              stop request, returns to RD_IDLE silently
//   need_read_o          request accepted and in progress
//   data_reg_o           read words, word k = beat k
//   rd_state_error_o     one-cycle error pulse (RD_ERROR)
//   rd_state_r_o         registered state
//   rd_state_next_o      combinational next state
//   bus_req_o            bus request (RD_ASK)
//   bus_addr_o           latched burst address
//   bus_size_o           latched burst code
//   bus_gnt_i            bus grant
//   bus_rvalid_i         read beat valid
//   bus_rdata_i          read beat data
//   bus_error_i          bus error

package ip_codma_machine_states_pkg;

    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_ASK     = 3'd1,
        RD_GRANTED = 3'd2,
        RD_DONE    = 3'd3,
        RD_ERROR   = 3'd4
    } rd_state_t;

endpackage

module ip_codma_read_machine
    import ip_codma_machine_states_pkg::*;
#(
    parameter int unsigned GNT_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             need_read_i,
    input  logic [31:0]      reg_addr_i,
    input  logic [7:0]       reg_size_i,
    input  logic             abort_i,
    output logic             need_read_o,
    output logic [7:0][31:0] data_reg_o,
    output logic             rd_state_error_o,
    output logic [2:0]       rd_state_r_o,
    output logic [2:0]       rd_state_next_o,
    output logic             bus_req_o,
    output logic [31:0]      bus_addr_o,
    output logic [7:0]       bus_size_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [31:0]      bus_rdata_i,
    input  logic             bus_error_i
);

    localparam logic [8:0] TIMEOUT = 9'(GNT_TIMEOUT);

    rd_state_t  state;
    rd_state_t  state_nx;
    logic [2:0] beat;
    logic [2:0] last_beat;
    logic [7:0] wait_cnt;
    logic       req_ok;
    logic       accept;
    logic       timeout;
    logic       take_beat;

    always_comb begin
        req_ok = ((reg_size_i == 8'd3) ||
                  (reg_size_i == 8'd8) ||
                  (reg_size_i == 8'd9)) &&
                 (reg_addr_i[1:0] == 2'b00);
    end

    // Last beat index follows the latched burst code, not the live input.
    always_comb begin
        last_beat = 3'd7;
        if (bus_size_o == 8'd3) begin
            last_beat = 3'd1;
        end else if (bus_size_o == 8'd8) begin
            last_beat = 3'd3;
        end
    end

    // wait_cnt counts RD_ASK cycles already spent; the current cycle
    // is the last one allowed when wait_cnt + 1 reaches the limit.
    always_comb begin
        timeout = (TIMEOUT != 9'd0) &&
                  (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT);
    end

    always_comb begin
        accept    = (state == RD_IDLE) && need_read_i;
        take_beat = (state == RD_GRANTED) && bus_rvalid_i &&
                    !abort_i && !bus_error_i;
    end

    // Priority outside IDLE: abort, then bus error, then progress.
    always_comb begin
        state_nx = state;
        unique case (state)
            RD_IDLE: begin
                if (need_read_i) begin
                    state_nx = req_ok ? RD_ASK : RD_ERROR;
                end
            end
            RD_ASK: begin
                if (abort_i) begin
                    state_nx = RD_IDLE;
                end else if (bus_error_i) begin
                    state_nx = RD_ERROR;
                end else if (bus_gnt_i) begin
                    state_nx = RD_GRANTED;
                end else if (timeout) begin
                    state_nx = RD_ERROR;
                end
            end
            RD_GRANTED: begin
                if (abort_i) begin
                    state_nx = RD_IDLE;
                end else if (bus_error_i) begin
                    state_nx = RD_ERROR;
                end else if (bus_rvalid_i && (beat == last_beat)) begin
                    state_nx = RD_DONE;
                end
            end
            RD_DONE: begin
                state_nx = RD_IDLE;
            end
            RD_ERROR: begin
                state_nx = RD_IDLE;
            end
            default: begin
                state_nx = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= RD_IDLE;
            need_read_o      <= 1'b0;
            bus_req_o        <= 1'b0;
            rd_state_error_o <= 1'b0;
            bus_addr_o       <= '0;
            bus_size_o       <= '0;
            data_reg_o       <= '0;
            beat             <= '0;
            wait_cnt         <= '0;
        end else begin
            state            <= state_nx;
            need_read_o      <= (state_nx == RD_ASK) ||
                                (state_nx == RD_GRANTED);
            bus_req_o        <= (state_nx == RD_ASK);
            rd_state_error_o <= (state_nx == RD_ERROR);
            if (accept) begin
                bus_addr_o <= reg_addr_i;
                bus_size_o <= reg_size_i;
                data_reg_o <= '0;
                beat       <= '0;
                wait_cnt   <= '0;
            end
            if (take_beat) begin
                data_reg_o[beat] <= bus_rdata_i;
                beat             <= beat + 3'd1;
            end
            if ((state == RD_ASK) && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign rd_state_r_o    = state;
    assign rd_state_next_o = state_nx;

endmodule
